// File: rtl/uart_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_pkg -- register offsets, CON bit map and TX FSM state encoding
// Rev 1.0
// ------------------------------------------------------------------
package uart_pkg;

  localparam logic [31:0] TXD_OFS = 32'h0000_0000;
  localparam logic [31:0] RXD_OFS = 32'h0000_0004;
  localparam logic [31:0] CON_OFS = 32'h0000_0008;

  localparam int CON_TX_IE   = 0;
  localparam int CON_RX_IE   = 1;
  localparam int CON_TX_DONE = 2;
  localparam int CON_RX_FULL = 3;
  localparam int CON_TX_FULL = 4;
  localparam int CON_TX_OVF  = 5;
  localparam int CON_RX_OVR  = 6;
  localparam int CON_W       = 7;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_tx_fifo -- byte FIFO, power-of-two depth, push accepted when full if popping
// Rev 1.0
// ------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/uart_bus_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_bus_ctrl -- memory-mapped UART front end: TXD/RXD/CON registers, TX FIFO, TX sequencer
// Rev 1.0
// ------------------------------------------------------------------
module uart_bus_ctrl #(
  parameter int          TX_DEPTH = 4,
  parameter logic [31:0] BASE     = 32'h4000_0018
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid
);
  import uart_pkg::*;

  localparam int          CW       = $clog2(TX_DEPTH) + 1;
  localparam logic [31:0] TXD_ADDR = BASE + TXD_OFS;
  localparam logic [31:0] RXD_ADDR = BASE + RXD_OFS;
  localparam logic [31:0] CON_ADDR = BASE + CON_OFS;

  tx_state_t        state;
  logic             sel_txd, sel_rxd, sel_con;
  logic             wr_txd, rd_rxd, rd_con, wr_con;
  logic             tx_ie, rx_ie, tx_done, rx_full, tx_ovf, rx_ovr, tx_full;
  logic [7:0]       rx_hold;
  logic             fifo_pop, fifo_full, fifo_empty, done_evt;
  logic [7:0]       fifo_dout;
  logic [CW-1:0]    fifo_count;
  logic [CON_W-1:0] con;
  logic             unused_wdata;

  assign sel_txd  = (addr == TXD_ADDR);
  assign sel_rxd  = (addr == RXD_ADDR);
  assign sel_con  = (addr == CON_ADDR);
  assign wr_txd   = mem_write & sel_txd;
  assign wr_con   = mem_write & sel_con;
  assign rd_rxd   = mem_read & sel_rxd;
  assign rd_con   = mem_read & sel_con;

  assign fifo_pop = (state == START);
  assign done_evt = (state == WAIT_DONE) & ~tx_busy;
  assign tx_full  = (fifo_count == CW'(TX_DEPTH));

  assign unused_wdata = ^wdata[31:8];

  uart_tx_fifo #(
    .DEPTH (TX_DEPTH)
  ) u_fifo (
    .clk   (sysclk),
    .reset (reset),
    .push  (wr_txd),
    .pop   (fifo_pop),
    .din   (wdata[7:0]),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // IDLE also looks at the incoming write so an empty block starts one cycle after it.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty || wr_txd) begin
            state    <= START;
            tx_start <= 1'b1;
            tx_data  <= fifo_empty ? wdata[7:0] : fifo_dout;
          end
        end
        START:     state <= WAIT_BUSY;
        WAIT_BUSY: if (tx_busy)  state <= WAIT_DONE;
        WAIT_DONE: if (!tx_busy) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  // Sticky flags: a set event in the same cycle as a CON read wins over the clear.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      tx_ie   <= 1'b0;
      rx_ie   <= 1'b0;
      tx_done <= 1'b0;
      tx_ovf  <= 1'b0;
      rx_ovr  <= 1'b0;
      rx_full <= 1'b0;
      rx_hold <= 8'h00;
    end else begin
      if (wr_con) begin
        tx_ie <= wdata[CON_TX_IE];
        rx_ie <= wdata[CON_RX_IE];
      end
      if (rd_con) begin
        tx_done <= 1'b0;
        tx_ovf  <= 1'b0;
        rx_ovr  <= 1'b0;
      end
      if (done_evt) tx_done <= 1'b1;
      if (wr_txd && fifo_full && !fifo_pop) tx_ovf <= 1'b1;
      if (rx_valid) begin
        rx_hold <= rx_data;
        rx_full <= 1'b1;
        if (rx_full && !rd_rxd) rx_ovr <= 1'b1;
      end else if (rd_rxd) begin
        rx_full <= 1'b0;
      end
    end
  end

  always_comb begin
    con              = '0;
    con[CON_TX_IE]   = tx_ie;
    con[CON_RX_IE]   = rx_ie;
    con[CON_TX_DONE] = tx_done;
    con[CON_RX_FULL] = rx_full;
    con[CON_TX_FULL] = tx_full;
    con[CON_TX_OVF]  = tx_ovf;
    con[CON_RX_OVR]  = rx_ovr;
  end

  always_comb begin
    rdata = 32'h0;
    if (sel_rxd)      rdata = {24'h0, rx_hold};
    else if (sel_con) rdata = {{(32-CON_W){1'b0}}, con};
  end

  assign irq = (tx_ie & tx_done) | (rx_ie & rx_full);

endmodule
`default_nettype wire

// File: tb/tb_uart_bus_ctrl.sv
`default_nettype none
// tb_uart_bus_ctrl -- scoreboard bench: stimulus pushes expected read data and TX bytes,
// a monitor pops and compares whenever the DUT reads out or starts a frame.
module tb_uart_bus_ctrl;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h4000_0018;
  localparam logic [31:0] A_TXD = BASE;
  localparam logic [31:0] A_RXD = BASE + 32'd4;
  localparam logic [31:0] A_CON = BASE + 32'd8;

  logic        sysclk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        irq, tx_start, tx_busy;
  logic [7:0]  tx_data;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;

  uart_bus_ctrl #(.TX_DEPTH(DEPTH), .BASE(BASE)) dut (
    .sysclk(sysclk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .irq(irq), .tx_data(tx_data),
    .tx_start(tx_start), .tx_busy(tx_busy), .rx_data(rx_data), .rx_valid(rx_valid)
  );

  always #5 sysclk = ~sysclk;

  int n_cmp = 0, n_err = 0, n_starts = 0;
  logic [7:0]  txq[$];
  logic [31:0] rdq[$];
  logic [31:0] miss_addr [4];

  // Reference model: register-level view of the block
  bit m_tx_ie, m_rx_ie, m_tx_done, m_rx_full, m_tx_full, m_tx_ovf, m_rx_ovr;
  logic [7:0] m_rx_hold;
  bit tx_active, snd_stall;
  int snd_fixed, snd_phase, snd_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] m_con();
    return {25'd0, m_rx_ovr, m_tx_ovf, m_tx_full, m_rx_full, m_tx_done, m_rx_ie, m_tx_ie};
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a == A_RXD) return {24'd0, m_rx_hold};
    if (a == A_CON) return m_con();
    return 32'd0;
  endfunction

  task automatic m_clear();
    {m_tx_ie, m_rx_ie, m_tx_done, m_rx_full, m_tx_full, m_tx_ovf, m_rx_ovr} = '0;
    m_rx_hold = 8'h00;
  endtask

  // One bus cycle: check irq from the previous edge, drive inputs, predict the closing edge.
  task automatic step(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                      input bit rxv, input logic [7:0] rxd);
    bit rd_rx;
    @(posedge sysclk); #1;
    if (!tx_active)
      chk("irq", {31'd0, irq}, {31'd0, (m_tx_ie & m_tx_done) | (m_rx_ie & m_rx_full)});
    mem_read = rd; mem_write = wr; addr = a; wdata = wd; rx_valid = rxv; rx_data = rxd;
    if (rd) rdq.push_back(m_read(a));
    rd_rx = rd && (a == A_RXD);
    if (rd && a == A_CON) begin m_tx_done = 0; m_tx_ovf = 0; m_rx_ovr = 0; end
    if (wr && a == A_CON) begin m_tx_ie = wd[0]; m_rx_ie = wd[1]; end
    if (rxv) begin
      if (m_rx_full && !rd_rx) m_rx_ovr = 1;
      m_rx_hold = rxd;
      m_rx_full = 1;
    end else if (rd_rx) begin
      m_rx_full = 0;
    end
  endtask

  task automatic idle();
    step(0, 0, 32'd0, 32'd0, 0, 8'h00);
  endtask

  task automatic idle_rx();
    step(0, 0, 32'd0, 32'd0, ($urandom_range(0, 3) == 0), 8'($urandom));
  endtask

  // Back-to-back TXD writes into an empty idle block; the sender holds busy while stalled,
  // so the first byte leaves immediately and DEPTH more fit, the rest overflow.
  task automatic burst(input int k, input bit stall, input logic [7:0] b0, input bit seq);
    logic [7:0] b;
    snd_stall = stall;
    tx_active = 1;
    for (int i = 0; i < k; i++) begin
      b = seq ? b0 + 8'(i) : 8'($urandom);
      step(0, 1, A_TXD, {24'd0, b}, 0, 8'h00);
      if (i <= DEPTH) txq.push_back(b);
      else m_tx_ovf = 1;
      if (i == 1) chk("tx_start_latency", {31'd0, tx_start}, 32'd1);
    end
    if (k == 1) begin
      idle();
      chk("tx_start_latency", {31'd0, tx_start}, 32'd1);
    end
    m_tx_full = (k - 1 >= DEPTH);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    snd_stall = 0;
    while (!(txq.size() == 0 && snd_phase == 0 && !tx_busy) && n < 400) begin
      idle_rx();
      n++;
    end
    chk("tx_drain_in_time", {31'd0, n < 400}, 32'd1);
    repeat (3) idle_rx();
    m_tx_done = 1; m_tx_full = 0; tx_active = 0;
  endtask

  task automatic do_reset();
    @(posedge sysclk); #1;
    reset = 1; mem_read = 0; mem_write = 0; rx_valid = 0;
    snd_stall = 0; snd_fixed = 0; tx_active = 0;
    txq.delete();
    m_clear();
    repeat (2) @(posedge sysclk);
    #1 reset = 0;
  endtask

  // Sender model: start delay 1..3 cycles, then busy for a few cycles (or while stalled).
  initial begin
    tx_busy = 0; snd_phase = 0; snd_cnt = 0;
    forever begin
      @(posedge sysclk); #1;
      if (reset) begin
        tx_busy = 0; snd_phase = 0;
      end else if (snd_phase == 0) begin
        if (tx_start) begin snd_phase = 1; snd_cnt = $urandom_range(1, 3); end
      end else if (snd_phase == 1) begin
        snd_cnt--;
        if (snd_cnt == 0) begin
          tx_busy = 1; snd_phase = 2;
          snd_cnt = (snd_fixed != 0) ? snd_fixed : $urandom_range(2, 6);
        end
      end else if (!snd_stall) begin
        snd_cnt--;
        if (snd_cnt <= 0) begin tx_busy = 0; snd_phase = 0; end
      end
    end
  end

  // Monitor
  initial begin
    logic [7:0] cur_tx;
    bit have_cur;
    have_cur = 0; cur_tx = 8'h00;
    forever begin
      @(negedge sysclk);
      if (reset) begin
        have_cur = 0;
      end else begin
        if (tx_start) begin
          n_starts++;
          if (txq.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL tx_start: got byte %0h, expected no frame", tx_data);
            have_cur = 0;
          end else begin
            cur_tx = txq.pop_front();
            have_cur = 1;
            chk("tx_data", {24'd0, tx_data}, {24'd0, cur_tx});
          end
        end else if (have_cur && tx_busy) begin
          chk("tx_data_hold", {24'd0, tx_data}, {24'd0, cur_tx});
        end
        if (mem_read) begin
          if (rdq.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL rdata: got %0h, expected no read", rdata);
          end else begin
            chk($sformatf("rdata@%0h", addr), rdata, rdq.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n;
    bit rxv;
    logic [7:0] rxb;
    miss_addr[0] = BASE - 32'd4;
    miss_addr[1] = BASE + 32'd1;
    miss_addr[2] = BASE + 32'd12;
    miss_addr[3] = BASE ^ 32'h1000_0000;
    tx_active = 0; snd_stall = 0; snd_fixed = 0;
    m_clear();
    repeat (3) @(posedge sysclk);
    #1 reset = 0;

    chk("rst_tx_data",  {24'd0, tx_data}, 32'd0);
    chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("rst_irq",      {31'd0, irq}, 32'd0);
    step(1, 0, A_CON, 0, 0, 0);
    step(1, 0, A_RXD, 0, 0, 0);
    step(1, 0, A_TXD, 0, 0, 0);
    idle();

    // Single byte 0x55, busy for 10 cycles, tx_ie and rx_ie enabled
    step(0, 1, A_CON, 32'h3, 0, 0);
    n0 = n_starts;
    snd_fixed = 10;
    burst(1, 0, 8'h55, 1);
    wait_idle();
    snd_fixed = 0;
    chk("tx_start_count", n_starts - n0, 32'd1);
    idle();
    chk("irq_tx_done", {31'd0, irq}, 32'd1);

    // RX overrun, then two CON reads (sticky bits cleared, enables kept)
    step(0, 0, 0, 0, 1, 8'hA3);
    step(0, 0, 0, 0, 1, 8'h7E);
    step(1, 0, A_RXD, 0, 0, 0);
    step(1, 0, A_CON, 0, 0, 0);
    step(1, 0, A_CON, 0, 0, 0);
    idle();

    // RXD read coinciding with a new byte
    step(0, 0, 0, 0, 1, 8'h22);
    step(1, 0, A_RXD, 0, 1, 8'h11);
    step(1, 0, A_CON, 0, 0, 0);
    step(1, 0, A_RXD, 0, 0, 0);
    idle();

    // Stalled sender: 0x01..0x06, last one overflows
    burst(6, 1, 8'h01, 1);
    step(1, 0, A_CON, 0, 0, 0);
    wait_idle();
    step(1, 0, A_CON, 0, 0, 0);

    // Randomized register traffic with periodic TX bursts
    for (int it = 0; it < 240; it++) begin
      rxv = ($urandom_range(0, 3) == 0);
      rxb = 8'($urandom);
      case ($urandom_range(0, 9))
        0, 1, 2: step(0, 0, 0, 0, rxv, rxb);
        3, 4:    step(1, 0, A_RXD, 0, rxv, rxb);
        5:       step(1, 0, A_CON, 0, rxv, rxb);
        6:       step(0, 1, A_CON, $urandom, rxv, rxb);
        7:       step(1, 0, miss_addr[$urandom_range(0, 3)], 0, rxv, rxb);
        8:       step(0, 1, miss_addr[$urandom_range(0, 3)], $urandom, rxv, rxb);
        default: step(1, 0, A_TXD, 0, rxv, rxb);
      endcase
      if (it % 60 == 59) begin
        burst($urandom_range(1, 7), 1, 8'h00, 0);
        step(1, 0, A_CON, 0, 0, 0);
        wait_idle();
        step(1, 0, A_CON, 0, 0, 0);
      end
    end
    idle();

    // Reset while a frame is in WAIT_DONE with three bytes queued
    burst(4, 1, 8'hC0, 1);
    n = 0;
    while (!tx_busy && n < 20) begin idle(); n++; end
    chk("busy_before_reset", {31'd0, tx_busy}, 32'd1);
    repeat (2) idle();
    do_reset();
    n0 = n_starts;
    repeat (20) idle();
    chk("no_tx_start_after_reset", n_starts - n0, 32'd0);
    chk("tx_data_after_reset", {24'd0, tx_data}, 32'd0);
    step(1, 0, A_CON, 0, 0, 0);
    idle();
    idle();
    chk("txq_drained", txq.size(), 32'd0);
    chk("rdq_drained", rdq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_bus_ctrl.md
UART_BUS_CTRL -- requirements
Module: uart_bus_ctrl

Interface
REQ-001 SHALL have parameter TX_DEPTH, default 4: TX FIFO entries, power of two, 2..16.
REQ-002 SHALL have parameter BASE, default 32'h4000_0018: byte address of TXD; RXD = BASE+4, CON = BASE+8.
REQ-003 SHALL have port sysclk  in  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port mem_read  in  1  CPU read strobe for the current cycle.
REQ-006 SHALL have port mem_write  in  1  CPU write strobe for the current cycle.
REQ-007 SHALL have port addr  in  32  CPU byte address.
REQ-008 SHALL have port wdata  in  32  CPU write data; only bits [7:0] are used for TXD and CON.
REQ-009 SHALL have port rdata  out  32  combinational read data; 0 when the address misses the block.
REQ-010 SHALL have port irq  out  1  level interrupt to the CPU.
REQ-011 SHALL have port tx_data  out  8  byte presented to the sender.
REQ-012 SHALL have port tx_start  out  1  one-cycle start pulse to the sender.
REQ-013 SHALL have port tx_busy  in  1  sender is shifting a frame.
REQ-014 SHALL have port rx_data  in  8  received byte; valid only while rx_valid is high.
REQ-015 SHALL have port rx_valid  in  1  one-cycle pulse marking a completed receive.

Function
REQ-016 SHALL decode addresses as follows:
  - exact 32-bit match only;
  - TXD write pushes wdata[7:0] into the TX FIFO;
  - TXD read returns 0;
  - RXD read returns {24'b0, rx_hold};
  - CON read/write uses the bit map in REQ-017.
REQ-017 SHALL implement CON with this bit map:
  - bit0 tx_ie (rw);
  - bit1 rx_ie (rw);
  - bit2 tx_done (sticky);
  - bit3 rx_full (ro);
  - bit4 tx_full (ro, FIFO count == TX_DEPTH);
  - bit5 tx_ovf (sticky);
  - bit6 rx_ovr (sticky);
  - bits 31:7 read as 0.
REQ-018 SHALL clear tx_done, tx_ovf and rx_ovr on the clock edge ending a CON read; a CON write updates only tx_ie and rx_ie.
REQ-019 SHALL, when a TXD write finds the FIFO full, drop the byte and set tx_ovf; FIFO contents are unchanged.
REQ-020 SHALL run the TX FSM with states IDLE, START, WAIT_BUSY, WAIT_DONE:
  - IDLE -> START when the FIFO is non-empty;
  - START: tx_start=1 for exactly one cycle, tx_data = FIFO head, head popped -> WAIT_BUSY;
  - WAIT_BUSY -> WAIT_DONE when tx_busy=1;
  - WAIT_DONE -> IDLE when tx_busy=0, setting tx_done on that edge.
REQ-021 SHALL hold tx_data stable from START until return to IDLE.
REQ-022 SHALL, on a same-cycle push and pop, keep the count unchanged and store the new byte; a full FIFO accepts such a push.
REQ-023 SHALL wrap FIFO read and write pointers modulo TX_DEPTH; count width is clog2(TX_DEPTH)+1.
REQ-024 SHALL, on rx_valid, load rx_hold and set rx_full; if rx_full is already 1 and no RXD read occurs that cycle, also set rx_ovr (the new byte overwrites).
REQ-025 SHALL, on an RXD read, clear rx_full at the closing edge unless rx_valid is high in that cycle; then the new byte loads, rx_full stays 1 and rx_ovr is not set.
REQ-026 SHALL drive irq = (tx_ie & tx_done) | (rx_ie & rx_full), combinationally from registers.
REQ-027 SHALL return read data in the same cycle as the read; read side effects take effect at the closing edge.
REQ-028 SHALL give a TXD write to an empty, idle block a latency of 1 cycle to START (tx_start high in the cycle after the write edge).

Reset
REQ-029 SHALL, on reset, clear the FIFO (pointers and count 0), put the FSM in IDLE, and set tx_start=0, tx_data=0, rx_hold=0 and every CON bit to 0, hence irq=0.
REQ-030 SHALL, on reset mid-frame, abandon the transfer immediately with no further tx_start; the sender is reset by the same signal.

Structure
REQ-031 SHALL place the CON bit indices, the TXD/RXD/CON offsets and the FSM state encodings in shared package uart_pkg.
REQ-032 SHALL implement the TX FIFO as the single sub-module uart_tx_fifo (push, pop, din, dout, count, full, empty).

Verification
REQ-033 SHALL verify: write TXD 0x55 with tx_busy modelled 10 cycles -> one tx_start, tx_data=0x55, tx_done=1 after busy falls, irq=1 when tx_ie=1.
REQ-034 SHALL verify: 5 TXD writes 0x01..0x05 with a stalled sender (TX_DEPTH=4) -> first byte sent, 0x02..0x05 queued, tx_full=1, a sixth write sets tx_ovf, bytes transmitted in order.
REQ-035 SHALL verify: rx_valid with 0xA3, then rx_valid with 0x7E before any RXD read -> RXD reads 0x7E, rx_ovr=1, rx_full=0 after the read.
REQ-036 SHALL verify: RXD read in the same cycle as rx_valid 0x11 -> old byte returned, rx_hold=0x11, rx_full stays 1, rx_ovr=0.
REQ-037 SHALL verify: reset asserted in WAIT_DONE with 3 bytes queued -> FIFO empty, state IDLE, irq=0, no tx_start for 20 cycles.
REQ-038 SHALL verify: CON read with tx_done=1 and rx_ovr=1 -> returns both set, next CON read returns both 0, tx_ie/rx_ie unchanged.
